// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer capture path.
package timer_pkg;

  localparam int unsigned TIMER_DW = 32;

  // FIFO entry when interval mode is built in; first marks a raw (non-delta) sample.
  typedef struct packed {
    logic [TIMER_DW-1:0] data;
    logic                first;
  } cap_entry_t;

  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/timer_fifo_mem.sv
// DEPTH x W register array: one synchronous write port, one combinational read port.
module timer_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  // Storage is left unreset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/timer_capture_fifo.sv
// Capture FIFO with level, threshold irq and sticky overflow status.
// Build option TIMER_CAP_DELTA_EN stores capture intervals and adds first_o.
module timer_capture_fifo
  import timer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = TIMER_DW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      dir,
  input  logic [DW-1:0]             cap_val,
  input  logic                      cap_stb,
  input  logic [lvl_w(DEPTH)-1:0]   thr,
  input  logic                      rd_en,
  output logic [DW-1:0]             rd_data,
  output logic                      empty,
  output logic                      full,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      ovf,
  output logic                      irq
`ifdef TIMER_CAP_DELTA_EN
  ,
  output logic                      first_o
`endif
);

  localparam int unsigned LW = lvl_w(DEPTH);
  localparam int unsigned AW = $clog2(DEPTH);
`ifdef TIMER_CAP_DELTA_EN
  localparam int unsigned EW = $bits(cap_entry_t);
`else
  localparam int unsigned EW = DW;
`endif

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] lvl_nxt;
  logic          push_req, do_push, do_pop;
  logic [EW-1:0] wr_word, rd_word;

  // Push/pop qualification; a pop frees the slot for a simultaneous push when full.
  always_comb begin
    push_req = cap_stb & en & ~clr;
    do_pop   = rd_en & ~empty & ~clr;
    do_push  = push_req & (~full | do_pop);
    lvl_nxt  = level;
    if (clr)                   lvl_nxt = '0;
    else if (do_push & ~do_pop) lvl_nxt = level + LW'(1);
    else if (do_pop & ~do_push) lvl_nxt = level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      ovf    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      wr_ptr <= clr ? '0 : (do_push ? wr_ptr + AW'(1) : wr_ptr);
      rd_ptr <= clr ? '0 : (do_pop  ? rd_ptr + AW'(1) : rd_ptr);
      level  <= lvl_nxt;
      empty  <= (lvl_nxt == '0);
      full   <= (lvl_nxt == LW'(DEPTH));
      ovf    <= clr ? 1'b0 : (ovf | (push_req & full & ~do_pop));
      irq    <= (thr != '0) && (lvl_nxt >= thr);
    end
  end

`ifdef TIMER_CAP_DELTA_EN
  logic [DW-1:0] prev;
  logic          have_prev;
  cap_entry_t    wr_entry, rd_entry;

  always_comb begin
    wr_entry.first = ~have_prev;
    wr_entry.data  = have_prev ? (dir ? cap_val - prev : prev - cap_val) : cap_val;
    wr_word        = wr_entry;
    rd_entry       = cap_entry_t'(rd_word);
  end

  // prev tracks every strobe that reaches the FIFO, dropped or not, so intervals stay exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (clr) begin
      have_prev <= 1'b0;
    end else if (push_req) begin
      prev      <= cap_val;
      have_prev <= 1'b1;
    end
  end

  assign rd_data = empty ? '0 : rd_entry.data;
  assign first_o = ~empty & rd_entry.first;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign wr_word    = cap_val;
  assign rd_data    = empty ? '0 : rd_word;
`endif

  timer_fifo_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_push),
    .wr_addr (wr_ptr),
    .wr_data (wr_word),
    .rd_addr (rd_ptr),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_timer_capture_fifo.sv
// Directed and randomized check of timer_capture_fifo against a queue model.
module tb_timer_capture_fifo;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, dir, cap_stb, rd_en;
  logic [31:0] cap_val, rd_data;
  logic [3:0]  thr, level;
  logic        empty, full, ovf, irq;
`ifdef TIMER_CAP_DELTA_EN
  logic        first_o;
`endif

  timer_capture_fifo #(.DEPTH(DEPTH), .DW(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .dir     (dir),
    .cap_val (cap_val),
    .cap_stb (cap_stb),
    .thr     (thr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .ovf     (ovf),
    .irq     (irq)
`ifdef TIMER_CAP_DELTA_EN
    ,
    .first_o (first_o)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: queue of {first, data}, sticky ovf, previous capture.
  logic [32:0] mq[$];
  logic        m_ovf, m_irq, m_have;
  logic [31:0] m_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    m_have = 1'b0;
    m_prev = '0;
  endtask

  task automatic model_step(input logic s, input logic [31:0] v, input logic r, input logic c);
    logic [32:0] e;
    if (c) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_have = 1'b0;
    end else begin
      if (r && mq.size() > 0) void'(mq.pop_front());
      if (s && en) begin
`ifdef TIMER_CAP_DELTA_EN
        e = m_have ? {1'b0, (dir ? v - m_prev : m_prev - v)} : {1'b1, v};
`else
        e = {1'b0, v};
`endif
        if (mq.size() < DEPTH) mq.push_back(e);
        else m_ovf = 1'b1;
        m_prev = v;
        m_have = 1'b1;
      end
    end
    m_irq = (thr != 0) && (mq.size() >= int'(thr));
  endtask

  task automatic check_all();
    chk("rd_data", rd_data, (mq.size() > 0) ? mq[0][31:0] : 32'd0);
    chk("empty",   32'(empty), 32'(mq.size() == 0));
    chk("full",    32'(full),  32'(mq.size() == DEPTH));
    chk("level",   32'(level), 32'(mq.size()));
    chk("ovf",     32'(ovf),   32'(m_ovf));
    chk("irq",     32'(irq),   32'(m_irq));
`ifdef TIMER_CAP_DELTA_EN
    chk("first_o", 32'(first_o), (mq.size() > 0) ? 32'(mq[0][32]) : 32'd0);
`endif
  endtask

  // One clock: drive at edge+1, model the edge, sample at next edge+1.
  task automatic step(input logic s, input logic [31:0] v, input logic r, input logic c);
    cap_stb = s;
    cap_val = v;
    rd_en   = r;
    clr     = c;
    model_step(s, v, r, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int bias;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; dir = 1'b0;
    cap_stb = 1'b0; cap_val = '0; rd_en = 1'b0; thr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    en = 1'b1;

    // T1: ordering and level sequence
    step(1, 100, 0, 0);
    chk("t1_head", rd_data, 32'd100);
    step(1, 90, 0, 0);
    step(1, 80, 0, 0);
    chk("t1_lvl3", 32'(level), 32'd3);
    step(0, 0, 1, 0);
    chk("t1_head2", rd_data, 32'd90);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t1_empty", 32'(empty), 32'd1);

    // T2: overflow drops the 9th sample, sticky until clr
    for (int i = 0; i < 9; i++) step(1, 32'(200 + i), 0, 0);
    chk("t2_lvl", 32'(level), 32'd8);
    chk("t2_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_pop", rd_data, 32'(200 + i));
      step(0, 0, 1, 0);
    end
    chk("t2_ovf_hold", 32'(ovf), 32'd1);
    step(0, 0, 0, 1);
    chk("t2_ovf_clr", 32'(ovf), 32'd0);

    // T3: push and pop while full
    for (int i = 0; i < 8; i++) step(1, 32'(300 + i), 0, 0);
    step(1, 999, 1, 0);
    chk("t3_lvl", 32'(level), 32'd8);
    chk("t3_ovf", 32'(ovf), 32'd0);
    chk("t3_head", rd_data, 32'd301);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // T4: threshold irq
    thr = 4'd3;
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    chk("t4_irq_lo", 32'(irq), 32'd0);
    step(1, 3, 0, 0);
    chk("t4_irq_hi", 32'(irq), 32'd1);
    step(0, 0, 1, 0);
    chk("t4_irq_fall", 32'(irq), 32'd0);
    thr = 4'd0;
    step(1, 4, 0, 0);
    step(1, 5, 0, 0);
    chk("t4_thr0", 32'(irq), 32'd0);

    // T5: clr beats push; en low blocks push
    step(1, 6, 0, 0);
    chk("t5_lvl5", 32'(level), 32'd5);
    step(1, 7, 0, 1);
    chk("t5_clr_lvl", 32'(level), 32'd0);
    step(1, 8, 0, 0);
    en = 1'b0;
    step(1, 9, 0, 0);
    chk("t5_en0", 32'(level), 32'd1);
    en = 1'b1;
    step(0, 0, 1, 0);

`ifdef TIMER_CAP_DELTA_EN
    // T6: interval mode, both directions
    dir = 1'b0;
    step(0, 0, 0, 1);
    step(1, 1000, 0, 0);
    step(1, 700, 0, 0);
    step(1, 650, 0, 0);
    chk("t6_raw", rd_data, 32'd1000);
    chk("t6_first", 32'(first_o), 32'd1);
    step(0, 0, 1, 0);
    chk("t6_d1", rd_data, 32'd300);
    chk("t6_notfirst", 32'(first_o), 32'd0);
    step(0, 0, 1, 0);
    chk("t6_d2", rd_data, 32'd50);
    step(0, 0, 1, 0);
    dir = 1'b1;
    step(0, 0, 0, 1);
    step(1, 32'hFFFF_FFF0, 0, 0);
    step(1, 32'h10, 0, 0);
    step(0, 0, 1, 0);
    chk("t6_wrap", rd_data, 32'h20);
    step(0, 0, 1, 0);
`endif

    // Mid-operation asynchronous reset
    step(1, 11, 0, 0);
    step(1, 12, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic with phase-varying push/pop bias
    bias = 2;
    for (int i = 0; i < 1600; i++) begin
      if (i % 200 == 0) begin
        bias = int'($urandom_range(0, 4));
        thr  = 4'($urandom_range(0, DEPTH));
      end
      en  = ($urandom_range(0, 7) != 0);
      dir = 1'($urandom);
      step(($urandom_range(0, 4) < 5 - bias),
           $urandom,
           ($urandom_range(0, 4) < bias),
           ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
